// File: rtl/multi_adder_if.sv
// Operand/result stream bundle for multi_adder.
// master: the side that supplies operands and abort, and consumes the result.
// slave:  the accumulator itself.
interface multi_adder_if #(
    parameter int WIDTH = 32,
    parameter int NOPS  = 4
);
    localparam int CW = $clog2(NOPS);

    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    count;

    modport master (
        output abort, in_valid, x,
        input  in_ready, out_valid, out, count
    );

    modport slave (
        input  abort, in_valid, x,
        output in_ready, out_valid, out, count
    );
endinterface

// File: rtl/multi_adder.sv
// N-operand accumulator: sums NOPS operands taken over a valid/ready stream and
// presents the result for HOLD cycles before clearing it to zero.
// Optional build macro ACC_SAT_EN: every add saturates at 2^WIDTH-1 instead of
// wrapping modulo 2^WIDTH. The port list is identical in either build.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACC   | accepting operands; acc/count track the partial sum
// DONE  | result on out with out_valid=1; hold counts up to HOLD-1
module multi_adder #(
    parameter int WIDTH = 32,
    parameter int NOPS  = 4,
    parameter int HOLD  = 1
) (
    input logic          clk,
    input logic          resetn,
    multi_adder_if.slave bus
);
    localparam int CW = $clog2(NOPS);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [CW-1:0] COUNT_LAST = CW'(NOPS - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD - 1);

    typedef enum logic {ACC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic [HW-1:0]    hold;
    logic [WIDTH-1:0] out_r;
    logic             out_valid_r;

    logic             accept;
    logic [WIDTH-1:0] sum;

    // Unsigned add of two operands; the carry either wraps or pins to full scale.
    function automatic logic [WIDTH-1:0] add_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
`ifdef ACC_SAT_EN
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    // Abort blocks acceptance in the same cycle so the aborted operand is dropped.
    always_comb begin
        bus.in_ready = (state == ACC) && !bus.abort;
        accept       = bus.in_valid && bus.in_ready;
        sum          = add_op(acc, bus.x);
    end

    // Accumulate, publish the finished sum, then hold and clear it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ACC;
            acc         <= '0;
            count       <= '0;
            hold        <= '0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (bus.abort) begin
                        acc   <= '0;
                        count <= '0;
                    end else if (accept) begin
                        if (count == '0) begin
                            acc   <= bus.x;
                            count <= CW'(1);
                        end else if (count == COUNT_LAST) begin
                            out_r       <= sum;
                            out_valid_r <= 1'b1;
                            acc         <= '0;
                            count       <= '0;
                            hold        <= '0;
                            state       <= DONE;
                        end else begin
                            acc   <= sum;
                            count <= count + CW'(1);
                        end
                    end
                end
                DONE: begin
                    // abort is deliberately ignored here: the result always
                    // completes its full hold window.
                    if (hold == HOLD_LAST) begin
                        out_r       <= '0;
                        out_valid_r <= 1'b0;
                        hold        <= '0;
                        state       <= ACC;
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    // Registered result and progress outputs.
    always_comb begin
        bus.out       = out_r;
        bus.out_valid = out_valid_r;
        bus.count     = count;
    end
endmodule

// File: tb/tb_multi_adder.sv
// Directed bench for multi_adder: two instances (HOLD=1 and HOLD=3, WIDTH=8,
// NOPS=3) share clock, reset and operand stimulus.
module tb_multi_adder;
    localparam int W = 8;
    localparam int N = 3;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    multi_adder_if #(.WIDTH(W), .NOPS(N)) if1 ();
    multi_adder_if #(.WIDTH(W), .NOPS(N)) if3 ();

    multi_adder #(.WIDTH(W), .NOPS(N), .HOLD(1)) dut1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if1.slave)
    );

    multi_adder #(.WIDTH(W), .NOPS(N), .HOLD(3)) dut3 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if3.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "time limit");
    end

    task automatic drive(input logic v, input logic [W-1:0] xv, input logic ab);
        if1.in_valid = v;  if1.x = xv;  if1.abort = ab;
        if3.in_valid = v;  if3.x = xv;  if3.abort = ab;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(1'b0, '0, 1'b0);
        cyc();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(1'b1, 8'd9, 1'b0);
        cyc();
        drive(1'b0, '0, 1'b0);
        #1;
        if (if1.out !== 8'd0) begin bad++; $display("FAIL reset_out got=%0d exp=0", if1.out); end
        total++;
        if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", if1.out_valid); end
        total++;
        if (if1.count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", if1.count); end
        total++;
        if (if1.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", if1.in_ready); end
        total++;
        if (if3.out_valid !== 1'b0 || if3.count !== 2'd0) begin
            bad++; $display("FAIL reset_dut3 got valid=%b count=%0d exp valid=0 count=0", if3.out_valid, if3.count);
        end
        total++;
        resetn = 1'b1;
    endtask

    task automatic test_basic_sum();
        do_reset();
        drive(1'b1, 8'd1, 1'b0);
        cyc();
        if (if1.count !== 2'd1) begin bad++; $display("FAIL basic_count1 got=%0d exp=1", if1.count); end
        total++;
        drive(1'b1, 8'd2, 1'b0);
        cyc();
        if (if1.count !== 2'd2) begin bad++; $display("FAIL basic_count2 got=%0d exp=2", if1.count); end
        total++;
        if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", if1.out_valid); end
        total++;
        drive(1'b1, 8'd3, 1'b0);
        cyc();
        drive(1'b0, '0, 1'b0);
        if (if1.out !== 8'd6 || if1.out_valid !== 1'b1) begin
            bad++; $display("FAIL basic_sum got out=%0d valid=%b exp out=6 valid=1", if1.out, if1.out_valid);
        end
        total++;
        if (if1.count !== 2'd0) begin bad++; $display("FAIL basic_count_clear got=%0d exp=0", if1.count); end
        total++;
        if (if1.in_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_done got=%b exp=0", if1.in_ready); end
        total++;
        cyc();
        if (if1.out !== 8'd0 || if1.out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_clear1 got out=%0d valid=%b exp out=0 valid=0", if1.out, if1.out_valid);
        end
        total++;
        if (if1.in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%b exp=1", if1.in_ready); end
        total++;
        if (if3.out !== 8'd6 || if3.out_valid !== 1'b1) begin
            bad++; $display("FAIL hold3_cycle2 got out=%0d valid=%b exp out=6 valid=1", if3.out, if3.out_valid);
        end
        total++;
        cyc();
        if (if3.out !== 8'd6 || if3.out_valid !== 1'b1) begin
            bad++; $display("FAIL hold3_cycle3 got out=%0d valid=%b exp out=6 valid=1", if3.out, if3.out_valid);
        end
        total++;
        cyc();
        if (if3.out !== 8'd0 || if3.out_valid !== 1'b0) begin
            bad++; $display("FAIL hold3_clear got out=%0d valid=%b exp out=0 valid=0", if3.out, if3.out_valid);
        end
        total++;
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp_v;
`ifdef ACC_SAT_EN
        exp_v = 8'd255;
`else
        exp_v = 8'd54;
`endif
        do_reset();
        drive(1'b1, 8'd200, 1'b0);
        cyc();
        drive(1'b1, 8'd100, 1'b0);
        cyc();
        drive(1'b1, 8'd10, 1'b0);
        cyc();
        drive(1'b0, '0, 1'b0);
        if (if1.out !== exp_v || if1.out_valid !== 1'b1) begin
            bad++; $display("FAIL wrap_sum got out=%0d valid=%b exp out=%0d valid=1", if1.out, if1.out_valid, exp_v);
        end
        total++;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_hold_backpressure();
        do_reset();
        drive(1'b1, 8'd1, 1'b0);
        cyc();
        drive(1'b1, 8'd2, 1'b0);
        cyc();
        drive(1'b1, 8'd3, 1'b0);
        cyc();
        drive(1'b1, 8'd7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (if3.in_ready !== 1'b0 || if3.out !== 8'd6 || if3.count !== 2'd0) begin
                bad++;
                $display("FAIL backpressure_%0d got ready=%b out=%0d count=%0d exp ready=0 out=6 count=0",
                         i, if3.in_ready, if3.out, if3.count);
            end
            total++;
            cyc();
        end
        if (if3.out_valid !== 1'b0 || if3.in_ready !== 1'b1 || if3.count !== 2'd0) begin
            bad++;
            $display("FAIL backpressure_release got valid=%b ready=%b count=%0d exp valid=0 ready=1 count=0",
                     if3.out_valid, if3.in_ready, if3.count);
        end
        total++;
        cyc();
        if (if3.count !== 2'd1) begin bad++; $display("FAIL back_to_back_first got=%0d exp=1", if3.count); end
        total++;
        drive(1'b1, 8'd8, 1'b0);
        cyc();
        drive(1'b1, 8'd9, 1'b0);
        cyc();
        drive(1'b0, '0, 1'b0);
        if (if3.out !== 8'd24 || if3.out_valid !== 1'b1) begin
            bad++; $display("FAIL back_to_back_sum got out=%0d valid=%b exp out=24 valid=1", if3.out, if3.out_valid);
        end
        total++;
    endtask

    task automatic test_abort();
        do_reset();
        drive(1'b1, 8'd9, 1'b0);
        cyc();
        cyc();
        if (if1.count !== 2'd2) begin bad++; $display("FAIL abort_pre_count got=%0d exp=2", if1.count); end
        total++;
        drive(1'b1, 8'd100, 1'b1);
        #1;
        if (if1.in_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", if1.in_ready); end
        total++;
        cyc();
        drive(1'b0, '0, 1'b0);
        if (if1.count !== 2'd0 || if1.out_valid !== 1'b0) begin
            bad++; $display("FAIL abort_clear got count=%0d valid=%b exp count=0 valid=0", if1.count, if1.out_valid);
        end
        total++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'd5, 1'b0);
            cyc();
        end
        drive(1'b0, '0, 1'b1);
        if (if1.out !== 8'd15 || if1.count !== 2'd0) begin
            bad++; $display("FAIL abort_resum got out=%0d count=%0d exp out=15 count=0", if1.out, if1.count);
        end
        total++;
        cyc();
        drive(1'b0, '0, 1'b0);
        if (if3.out !== 8'd15 || if3.out_valid !== 1'b1) begin
            bad++; $display("FAIL abort_in_done got out=%0d valid=%b exp out=15 valid=1", if3.out, if3.out_valid);
        end
        total++;
        cyc();
        cyc();
        if (if3.out_valid !== 1'b0) begin bad++; $display("FAIL abort_done_end got=%b exp=0", if3.out_valid); end
        total++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 8'd4, 1'b0);
        cyc();
        cyc();
        resetn = 1'b0;
        drive(1'b0, '0, 1'b0);
        cyc();
        resetn = 1'b1;
        if (if1.count !== 2'd0 || if1.out_valid !== 1'b0 || if1.out !== 8'd0 || if1.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_sum got count=%0d valid=%b out=%0d ready=%b exp 0 0 0 1",
                     if1.count, if1.out_valid, if1.out, if1.in_ready);
        end
        total++;
        drive(1'b1, 8'd1, 1'b0);
        cyc();
        cyc();
        cyc();
        drive(1'b0, '0, 1'b0);
        if (if3.out !== 8'd3) begin bad++; $display("FAIL reset_mid_resum got=%0d exp=3", if3.out); end
        total++;
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        if (if3.count !== 2'd0 || if3.out_valid !== 1'b0 || if3.out !== 8'd0 || if3.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_done got count=%0d valid=%b out=%0d ready=%b exp 0 0 0 1",
                     if3.count, if3.out_valid, if3.out, if3.in_ready);
        end
        total++;
    endtask

    task automatic test_gaps();
        logic [W-1:0] vals [3];
        logic [1:0]   exp_c;
        vals[0] = 8'd4;
        vals[1] = 8'd5;
        vals[2] = 8'd6;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, vals[k], 1'b0);
            cyc();
            drive(1'b0, 8'd99, 1'b0);
            if (k < 2) begin
                exp_c = 2'(k + 1);
                if (if1.count !== exp_c) begin
                    bad++; $display("FAIL gap_count_%0d got=%0d exp=%0d", k, if1.count, exp_c);
                end
                total++;
                cyc();
                cyc();
                if (if1.count !== exp_c) begin
                    bad++; $display("FAIL gap_idle_%0d got=%0d exp=%0d", k, if1.count, exp_c);
                end
                total++;
            end
        end
        if (if1.out !== 8'd15 || if1.out_valid !== 1'b1) begin
            bad++; $display("FAIL gap_sum got out=%0d valid=%b exp out=15 valid=1", if1.out, if1.out_valid);
        end
        total++;
    endtask

    // Sequence the scenarios and report.
    initial begin
        drive(1'b0, '0, 1'b0);
        test_reset();
        test_basic_sum();
        test_wrap();
        test_hold_backpressure();
        test_abort();
        test_reset_mid();
        test_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
